// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_subtractor_pkg;

    localparam int unsigned SUB_WIDTH_DEFAULT = 4;
    localparam int unsigned SUB_CW_DEFAULT    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from two half-subtractor stages.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // First half subtractor: a - b
    assign hs1_d = a ^ b;
    assign hs1_b = ~a & b;

    // Second half subtractor: (a - b) - bin
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    // Either stage may generate the borrow
    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = P - Q, LSB first, one bit per clock.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT,
    parameter int unsigned CW    = SUB_CW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   Diff
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_e       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] r_q,      r_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH:0]   diff_q,   diff_d;

    logic             fs_d;
    logic             fs_bout;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // State, datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            diff_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            diff_q   <= diff_d;
        end
    end

    // Next-state and datapath update; DONE accepts start like IDLE for back-to-back runs
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        diff_d   = diff_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d      = P;
                    b_d      = Q;
                    r_d      = '0;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                r_d      = {fs_d, r_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = fs_bout;
                count_d  = count_q + CW'(1);
                if (count_q == LAST_BIT) begin
                    // Final bit and borrow go straight into Diff, bypassing r_q
                    diff_d  = {fs_bout, fs_d, r_q[WIDTH-1:1]};
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign Diff = diff_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor. Computes Diff = P − Q, one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion to the team's ripple-carry adder. Its output uses the same WIDTH+1 result format, with the extra MSB carrying sign/borrow.
- Used where area matters more than latency, and wherever a datapath needs P − Q alongside P + Q.
- Start/busy/done handshake towards the controlling FSM.

Parameters:
- WIDTH, 4, operand width in bits. Diff is WIDTH+1 bits.
- CW, 3, counter width. Must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled only in IDLE or DONE.
- P  input  WIDTH  minuend. Captured on the accepted start edge.
- Q  input  WIDTH  subtrahend. Captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when Diff becomes valid.
- Diff  output  WIDTH+1  two's-complement P − Q. Diff[WIDTH] = final borrow (1 = negative).

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). rst forces: state=IDLE, busy=0, done=0, Diff=0, borrow=0, count=0, shift registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE + start=1:
  - Load A<=P, B<=Q, borrow<=0, count<=0, R<=0; go to SHIFT.
  - Diff keeps its previous value.
- SHIFT, each cycle:
  - a=A[0], b=B[0], bin=borrow.
  - d = a^b^bin.
  - bout = (~a&b) | (~(a^b)&bin).
  - R <= {d, R[WIDTH-1:1]}; A, B shift right by 1; borrow<=bout; count<=count+1.
  - On the cycle where count==WIDTH-1: go to DONE and register Diff <= {bout, d, R[WIDTH-1:1]}, i.e. the full result including the final bit.
- DONE: done=1 for exactly this cycle, then IDLE. If start=1 in DONE, accept it exactly as in IDLE (back-to-back operations, no idle gap).
- Latency: start sampled at edge N → done=1 and Diff valid during the cycle after edge N+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Result semantics:
  - Diff equals the exact signed value P − Q in the range −(2^WIDTH−1) .. +(2^WIDTH−1).
  - Diff[WIDTH] is the borrow-out, equivalent to ~carry of P + ~Q + 1.
- Boundary conditions:
  - start while busy: ignored, no effect on the operation in progress.
  - P/Q changing after the accepted start: no effect.
  - P==Q: Diff=0, borrow 0.
  - Diff holds its value until the next completion or reset.
  - rst asserted mid-SHIFT: immediate abort, all state to reset values, no done pulse.
  - start held high continuously: a new operation starts every WIDTH+1 cycles.
- busy = (state==SHIFT), registered/decoded from state. No combinational path from start to busy/done.

Decomposition:
- Shared package: state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2) and the default WIDTH constant. The package is shared with future serial arithmetic blocks.
- Sub-module full_subtractor (a, b, bin → d, bout): gate-level, built from half-subtractor style xor/and/or primitives, mirroring the adder's full-adder cell.
- Top level holds the FSM, counter, shift registers and borrow flip-flop.

Test Plan:
- P=9, Q=3, start pulse → busy for 4 cycles; done at cycle 5; Diff=5'b00110 (+6).
- P=3, Q=9 → Diff=5'b11010 (−6), Diff[4]=1.
- Extremes:
  - P=15, Q=0 → 5'b01111.
  - P=0, Q=15 → 5'b10001.
  - P=7, Q=7 → 5'b00000.
- P=12, Q=5 started; start re-pulsed with P=1, Q=1 during SHIFT → ignored; Diff=5'b00111; exactly one done pulse.
- P=10, Q=4 started; rst pulsed at SHIFT cycle 2 → busy=0, done=0, Diff=0 immediately; a subsequent P=10, Q=4 run → Diff=5'b00110.
- start held high with P=8, Q=2 then P=2, Q=8 → done pulses every 5 cycles; Diff=5'b00110 then 5'b11010.
- Exhaustive sweep over all 256 (P,Q) pairs → Diff must equal the reference value P − Q.
